// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one equality comparator among NUM_REQ requesters.
// One compare in flight at a time: IDLE grants, CMP evaluates, RESP holds the result until taken.
module compare_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = ($clog2(NUM_REQ) > 0) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic                          rsp_eq,
    output logic [ID_W-1:0]               rsp_id,
    input  logic                          rsp_ready,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       ptr_nxt;
    logic [NUM_REQ-1:0]    grant_onehot;
    logic                  grant_any;
    logic                  accept;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [ID_W-1:0]       id_reg;
    logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[g] = req_b[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or after rr_ptr, wrapping past the top index.
    always_comb begin
        int cand;
        cand         = 0;
        grant_any    = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
                grant_any                    = 1'b1;
                grant_idx                    = cand[ID_W-1:0];
                grant_onehot[cand[ID_W-1:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE)) begin
            req_ready = grant_onehot;
        end
    end

    assign accept = grant_any && (state == IDLE) && |(req_valid & req_ready);
    assign busy   = (state != IDLE);

    always_comb begin
        ptr_nxt = '0;
        if (grant_idx != ID_W'(NUM_REQ - 1)) begin
            ptr_nxt = grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CMP;
            CMP:     state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The pointer advances only on an actual accept, so idle cycles keep the rotation position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            id_reg    <= '0;
            rsp_valid <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= a_arr[grant_idx];
                        b_reg  <= b_arr[grant_idx];
                        id_reg <= grant_idx;
                        rr_ptr <= ptr_nxt;
                    end
                end
                CMP: begin
                    rsp_eq    <= (a_reg == b_reg);
                    rsp_id    <= id_reg;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
